sme_stream_feeder: RTL and testbench

//  Upstream front end for the SME string-match engine. Accepts framed records (string or pattern)
//  on a valid/ready byte stream and buffers them in a FIFO. Replays each complete record to SME as
//  a gap-free chardata burst with isstring/ispattern held high. After each pattern it waits for
//  SME valid and returns the result (or a timeout) on a one-cycle result port.

---
 rtl/sme_stream_feeder_if.sv | 19 +
 rtl/sme_stream_feeder.sv | 168 ++++++++++++++++
 tb/tb_sme_stream_feeder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sme_stream_feeder_if.sv
// Framed byte stream into the SME feeder.
// One beat moves per cycle with s_valid and s_ready both high.
interface sme_stream_feeder_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_kind;
  logic       s_last;

  modport master (
    output s_valid, s_data, s_kind, s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, s_kind, s_last,
    output s_ready
  );
endinterface

// File: rtl/sme_stream_feeder.sv
// Buffers framed string/pattern records and replays them to SME as
// gap-free bursts, then returns the SME result or a timeout.
module sme_stream_feeder #(
  parameter int FIFO_DEPTH = 64,
  parameter int STR_MAX    = 32,
  parameter int PAT_MAX    = 8,
  parameter int TIMEOUT    = 4095
) (
  input  logic                clk,
  input  logic                reset,
  sme_stream_feeder_if.slave  in_s,
  output logic [7:0]          chardata,
  output logic                isstring,
  output logic                ispattern,
  input  logic                sme_valid,
  input  logic                sme_match,
  input  logic [4:0]          sme_match_index,
  output logic                res_valid,
  output logic                res_match,
  output logic [4:0]          res_index,
  output logic                res_timeout,
  output logic                err_len,
  output logic                busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LM = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
  localparam int WW = $clog2(LM + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic       kind;
    logic       last;
    logic [7:0] data;
  } ent_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    WAIT
  } state_t;

  ent_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, rec_cnt;
  logic [WW-1:0] wcnt, lim;
  logic [TW-1:0] tcnt;
  logic          drop;
  state_t        state;

  logic full, empty, accept, hit;
  logic wr_en, wr_last, pop;
  ent_t rd;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign in_s.s_ready = !reset && !full;
  assign accept  = in_s.s_valid && in_s.s_ready;
  assign lim     = in_s.s_kind ? WW'(PAT_MAX) : WW'(STR_MAX);
  assign hit     = ((wcnt + 1'b1) == lim);
  assign wr_en   = accept && !drop;
  assign wr_last = in_s.s_last || hit;
  assign pop     = (state == SEND);
  assign rd      = mem[rptr];
  assign busy    = !reset && ((state != IDLE) || !empty);

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr] <= '{kind: in_s.s_kind, last: wr_last,
                     data: in_s.s_data};
  end

  // Write side: truncation bookkeeping plus FIFO occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      rec_cnt <= '0;
      wcnt    <= '0;
      drop    <= 1'b0;
      err_len <= 1'b0;
    end else begin
      if (accept) begin
        if (drop) begin
          err_len <= 1'b1;
          if (in_s.s_last) begin
            drop <= 1'b0;
            wcnt <= '0;
          end
        end else if (in_s.s_last) begin
          wcnt <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
          drop <= hit;
        end
      end
      if (wr_en)
        wptr <= inc(wptr);
      if (pop)
        rptr <= inc(rptr);
      count   <= count + CW'(wr_en) - CW'(pop);
      rec_cnt <= rec_cnt + CW'(wr_en && wr_last)
                         - CW'(pop && rd.last);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tcnt        <= '0;
      chardata    <= '0;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
      res_valid   <= 1'b0;
      res_match   <= 1'b0;
      res_index   <= '0;
      res_timeout <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      isstring  <= 1'b0;
      ispattern <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rec_cnt != '0)
            state <= SEND;
        end
        SEND: begin
          chardata  <= rd.data;
          isstring  <= !rd.kind;
          ispattern <= rd.kind;
          if (rd.last)
            state <= rd.kind ? WAIT : GAP;
        end
        GAP: begin
          state <= IDLE;
        end
        WAIT: begin
          if (sme_valid) begin
            res_valid   <= 1'b1;
            res_match   <= sme_match;
            res_index   <= sme_match_index;
            res_timeout <= 1'b0;
            tcnt        <= '0;
            state       <= IDLE;
          end else if (tcnt == TW'(TIMEOUT)) begin
            res_valid   <= 1'b1;
            res_match   <= 1'b0;
            res_index   <= '0;
            res_timeout <= 1'b1;
            tcnt        <= '0;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_stream_feeder.sv
// Directed scoreboard bench for sme_stream_feeder: a 64-deep
// instance for the main flows and an 8-deep one for full/wrap.
module tb_sme_stream_feeder;

  logic clk, reset, sel;
  logic tv, tk, tl;
  logic [7:0] td;
  logic tsv, tsm;
  logic [4:0] tsi;

  sme_stream_feeder_if ia();
  sme_stream_feeder_if ib();

  assign ia.s_valid = tv && !sel;
  assign ia.s_data  = td;
  assign ia.s_kind  = tk;
  assign ia.s_last  = tl;
  assign ib.s_valid = tv && sel;
  assign ib.s_data  = td;
  assign ib.s_kind  = tk;
  assign ib.s_last  = tl;

  logic [7:0] a_char, b_char;
  logic a_str, a_pat, a_rv, a_rm, a_rt, a_err, a_busy;
  logic b_str, b_pat, b_rv, b_rm, b_rt, b_err, b_busy;
  logic [4:0] a_ri, b_ri;

  sme_stream_feeder #(
    .FIFO_DEPTH(64), .STR_MAX(32), .PAT_MAX(8), .TIMEOUT(16)
  ) dut_a (
    .clk(clk), .reset(reset), .in_s(ia),
    .chardata(a_char), .isstring(a_str), .ispattern(a_pat),
    .sme_valid(tsv && !sel), .sme_match(tsm),
    .sme_match_index(tsi),
    .res_valid(a_rv), .res_match(a_rm), .res_index(a_ri),
    .res_timeout(a_rt), .err_len(a_err), .busy(a_busy)
  );

  sme_stream_feeder #(
    .FIFO_DEPTH(8), .STR_MAX(8), .PAT_MAX(8), .TIMEOUT(16)
  ) dut_b (
    .clk(clk), .reset(reset), .in_s(ib),
    .chardata(b_char), .isstring(b_str), .ispattern(b_pat),
    .sme_valid(tsv && sel), .sme_match(tsm),
    .sme_match_index(tsi),
    .res_valid(b_rv), .res_match(b_rm), .res_index(b_ri),
    .res_timeout(b_rt), .err_len(b_err), .busy(b_busy)
  );

  logic [7:0] m_char;
  logic m_str, m_pat, m_rv, m_rm, m_rt, m_err, m_busy, tready;
  logic [4:0] m_ri;

  assign m_char = sel ? b_char : a_char;
  assign m_str  = sel ? b_str  : a_str;
  assign m_pat  = sel ? b_pat  : a_pat;
  assign m_rv   = sel ? b_rv   : a_rv;
  assign m_rm   = sel ? b_rm   : a_rm;
  assign m_ri   = sel ? b_ri   : a_ri;
  assign m_rt   = sel ? b_rt   : a_rt;
  assign m_err  = sel ? b_err  : a_err;
  assign m_busy = sel ? b_busy : a_busy;
  assign tready = sel ? ib.s_ready : ia.s_ready;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int run = 0;
  int last_pat_cyc = 0;
  int res_cyc = 0;

  logic [8:0] exp_q[$];
  int         len_q[$];
  logic [6:0] res_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard as the DUT drives SME/results.
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else begin
      if (m_str && m_pat)
        chk("both_flags", 1, 0);
      if (m_str || m_pat) begin
        run++;
        if (m_pat)
          last_pat_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("char_unexpected", {m_pat, m_char}, 0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("char", {m_pat, m_str, m_char},
              {e[8], ~e[8], e[7:0]});
        end
      end else if (run != 0) begin
        if (len_q.size() == 0)
          chk("burst_unexpected", run, 0);
        else
          chk("burst_len", run, len_q.pop_front());
        run = 0;
      end
      if (m_rv) begin
        res_cyc = cyc;
        if (res_q.size() == 0)
          chk("res_unexpected", {m_rm, m_ri, m_rt}, 0);
        else
          chk("result", {m_rm, m_ri, m_rt}, res_q.pop_front());
      end
    end
  end

  task automatic beat(input logic [7:0] d, input logic k,
                      input logic l);
    int n;
    n = 0;
    tv = 1'b1; td = d; tk = k; tl = l;
    while (!tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300)
      chk("ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    tv = 1'b0;
  endtask

  task automatic send_rec(input string s, input int n,
                          input logic k, input int gap);
    int mx;
    mx = sel ? 8 : (k ? 8 : 32);
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      d = (s.len() > 0) ? s[i] : 8'(65 + i % 26);
      if (i < mx)
        exp_q.push_back({k, d});
      beat(d, k, i == n - 1);
      if (gap > 0 && i != n - 1) begin
        repeat (gap) @(negedge clk);
        chk("early_drive", {m_str, m_pat}, 0);
      end
    end
    len_q.push_back(n < mx ? n : mx);
  endtask

  task automatic reply(input logic m, input logic [4:0] idx);
    int n;
    n = 0;
    while (!m_pat && n < 500) begin
      @(negedge clk);
      n++;
    end
    while (m_pat && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reply_wait", n < 500, 1);
    tsv = 1'b1; tsm = m; tsi = idx;
    @(negedge clk);
    tsv = 1'b0; tsm = 1'b0; tsi = '0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_busy || exp_q.size() != 0 || res_q.size() != 0
            || len_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain", n < budget, 1);
  endtask

  initial begin
    int n;
    reset = 1'b1; sel = 1'b0;
    tv = 1'b0; td = '0; tk = 1'b0; tl = 1'b0;
    tsv = 1'b0; tsm = 1'b0; tsi = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", tready, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_flags", {m_str, m_pat}, 0);
    chk("rst_res", {m_rv, m_rm, m_ri, m_rt}, 0);
    chk("rst_err", m_err, 0);
    chk("rst_char", m_char, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", tready, 1);

    res_q.push_back({1'b1, 5'd1, 1'b0});
    send_rec("abcd", 4, 1'b0, 0);
    send_rec("bc", 2, 1'b1, 0);
    reply(1'b1, 5'd1);
    drain(300);

    res_q.push_back({1'b0, 5'd0, 1'b1});
    send_rec("zz", 2, 1'b1, 0);
    drain(300);
    chk("timeout_latency", res_cyc - last_pat_cyc, 17);

    send_rec("", 40, 1'b0, 0);
    chk("err_set", m_err, 1);
    res_q.push_back({1'b0, 5'd3, 1'b0});
    send_rec("ab", 2, 1'b1, 0);
    reply(1'b0, 5'd3);
    drain(300);
    chk("err_sticky", m_err, 1);

    send_rec("hello", 5, 1'b0, 2);
    drain(300);

    sel = 1'b1;
    @(negedge clk);
    res_q.push_back({1'b0, 5'd0, 1'b1});
    send_rec("p", 1, 1'b1, 0);
    send_rec("012345", 6, 1'b0, 0);
    send_rec("67", 2, 1'b1, 0);
    chk("full_ready", tready, 0);
    chk("full_busy", m_busy, 1);
    res_q.push_back({1'b0, 5'd0, 1'b1});
    send_rec("Q", 1, 1'b0, 0);
    drain(400);
    sel = 1'b0;
    @(negedge clk);

    send_rec("wxyz", 4, 1'b1, 0);
    n = 0;
    while (!(m_pat && m_char == 8'h79) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("third_char_seen", n < 100, 1);
    reset = 1'b1;
    exp_q.delete();
    len_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    chk("mid_rst_flags", {m_str, m_pat}, 0);
    chk("mid_rst_busy", m_busy, 0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    chk("post_rst_busy", m_busy, 0);
    chk("post_rst_err", m_err, 0);

    res_q.push_back({1'b1, 5'd2, 1'b0});
    send_rec("fresh", 5, 1'b0, 0);
    send_rec("es", 2, 1'b1, 0);
    reply(1'b1, 5'd2);
    drain(300);
    chk("end_busy", m_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
